// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the fetch/load-store memory arbiter.
// State encodings and a small width helper used by the arbiter and its watchdog.
package mem_arbiter_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_WAIT_I = 2'd1;
  localparam logic [1:0] ARB_WAIT_D = 2'd2;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Response watchdog: counts cycles while a response is awaited and flags
// expiry on the TIMEOUT-th waiting cycle. Held at zero when not running.
module arb_watchdog
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam int TW = cnt_width(TIMEOUT);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || !run) begin
      count <= '0;
    end else begin
      count <= count + TW'(1);
    end
  end

  assign expire = run && (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and load/store,
// one outstanding read at a time, data-first with a bounded fetch starvation.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic [3:0]      d_wea,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wea,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            err_timeout,
  output logic [1:0]      state_dbg
);

  localparam int SW = cnt_width(MAX_D_STREAK);

  logic [1:0]    state, state_nxt;
  logic [SW-1:0] streak, streak_nxt;
  logic          in_idle, in_wait, pick_i, pick_d, wd_expire, rsp_done;

  // Handshake: a request is accepted in the cycle where mem_req and mem_ready
  // are both high; the granted requester sees its gnt in that same cycle and
  // must hold req/addr/data stable until then.
  assign in_idle = reset && (state == ARB_IDLE);
  assign in_wait = (state == ARB_WAIT_I) || (state == ARB_WAIT_D);

  assign pick_i = if_req && (!d_req || (streak == SW'(MAX_D_STREAK)));
  assign pick_d = d_req && !pick_i;

  assign mem_req   = in_idle && (if_req || d_req);
  assign if_gnt    = mem_req && pick_i && mem_ready;
  assign d_gnt     = mem_req && pick_d && mem_ready;
  assign mem_addr  = !mem_req ? '0 : (pick_d ? d_addr : if_addr);
  assign mem_wea   = (mem_req && pick_d) ? d_wea : 4'h0;
  assign mem_wdata = (mem_req && pick_d) ? d_wdata : '0;

  // Real data on the expiry cycle takes precedence over the timeout.
  assign rsp_done    = in_wait && (mem_rvalid || wd_expire);
  assign err_timeout = wd_expire && !mem_rvalid;

  assign if_rvalid = rsp_done && (state == ARB_WAIT_I);
  assign d_rvalid  = rsp_done && (state == ARB_WAIT_D);
  assign if_rdata  = ((state == ARB_WAIT_I) && mem_rvalid) ? mem_rdata : '0;
  assign d_rdata   = ((state == ARB_WAIT_D) && mem_rvalid) ? mem_rdata : '0;
  assign state_dbg = state;

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .run   (in_wait),
    .clear (rsp_done),
    .expire(wd_expire)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (if_gnt) begin
          state_nxt = ARB_WAIT_I;
        end else if (d_gnt && (d_wea == 4'h0)) begin
          state_nxt = ARB_WAIT_D;
        end
      end
      ARB_WAIT_I, ARB_WAIT_D: begin
        if (rsp_done) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    streak_nxt = streak;
    if (if_gnt) begin
      streak_nxt = '0;
    end else if (d_gnt) begin
      if (!if_req) begin
        streak_nxt = '0;
      end else if (streak != SW'(MAX_D_STREAK)) begin
        streak_nxt = streak + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ARB_IDLE;
      streak <= '0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: decode table, directed multi-cycle sequences and a
// randomized run scored against a cycle-level reference model.
module tb_mem_arbiter;
  localparam int XLEN = 32;
  localparam int MAXS = 4;
  localparam int TMO  = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            if_req, if_gnt, if_rvalid;
  logic [XLEN-1:0] if_addr, if_rdata;
  logic            d_req, d_gnt, d_rvalid;
  logic [3:0]      d_wea, mem_wea;
  logic [XLEN-1:0] d_addr, d_wdata, d_rdata;
  logic            mem_req, mem_ready, mem_rvalid, err_timeout;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]      state_dbg;

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  typedef struct {
    logic        i_req;
    logic        dq;
    logic [3:0]  wea;
    logic        rdy;
    logic        e_ig;
    logic        e_dg;
    logic        e_mr;
    logic [31:0] e_addr;
    logic [3:0]  e_wea;
    logic [31:0] e_wdata;
  } vec_t;
  vec_t tbl[12];

  mem_arbiter #(.XLEN(XLEN), .MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_wea(d_wea), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wea(mem_wea),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .err_timeout(err_timeout), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    if_req = 0; if_addr = '0; d_req = 0; d_wea = '0; d_addr = '0; d_wdata = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  // Cycle-level reference model state
  int owner, since, streak;
  logic e_ig, e_dg, e_mr, e_irv, e_drv, e_err, complete;
  logic [31:0] e_addr, e_wdata, e_ird, e_drd;
  logic [3:0] e_wea;
  logic drop_i, drop_d;

  initial begin
    clear_inputs();
    //             ir dr wea   rdy ig dg mr addr          wea   wdata
    tbl[0]  = '{0, 0, 4'h0, 1, 0, 0, 0, 32'h0,        4'h0, 32'h0};
    tbl[1]  = '{1, 0, 4'h0, 0, 0, 0, 1, 32'h4000_0000, 4'h0, 32'h0};
    tbl[2]  = '{0, 1, 4'h0, 0, 0, 0, 1, 32'h2004,      4'h0, 32'hDEAD_BEEF};
    tbl[3]  = '{1, 1, 4'h3, 0, 0, 0, 1, 32'h2004,      4'h3, 32'hDEAD_BEEF};
    tbl[4]  = '{0, 1, 4'h3, 1, 0, 1, 1, 32'h2004,      4'h3, 32'hDEAD_BEEF};
    tbl[5]  = '{1, 1, 4'hF, 1, 0, 1, 1, 32'h2004,      4'hF, 32'hDEAD_BEEF};
    tbl[6]  = '{1, 1, 4'hF, 1, 0, 1, 1, 32'h2004,      4'hF, 32'hDEAD_BEEF};
    tbl[7]  = '{1, 1, 4'hF, 1, 0, 1, 1, 32'h2004,      4'hF, 32'hDEAD_BEEF};
    tbl[8]  = '{1, 1, 4'hF, 1, 0, 1, 1, 32'h2004,      4'hF, 32'hDEAD_BEEF};
    tbl[9]  = '{1, 1, 4'hF, 0, 0, 0, 1, 32'h4000_0000, 4'h0, 32'h0};
    tbl[10] = '{0, 1, 4'hF, 1, 0, 1, 1, 32'h2004,      4'hF, 32'hDEAD_BEEF};
    tbl[11] = '{1, 1, 4'hF, 0, 0, 0, 1, 32'h2004,      4'hF, 32'hDEAD_BEEF};

    // Reset values, with requests pending while reset is held
    if_req = 1; d_req = 1; mem_ready = 1; mem_rvalid = 1;
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_gnt", {if_gnt, d_gnt}, 0);
    chk("rst_rvalid", {if_rvalid, d_rvalid, err_timeout}, 0);
    chk("rst_state", state_dbg, 0);
    do_reset();

    // Idle decode table: stores only, so the arbiter never leaves IDLE
    if_addr = 32'h4000_0000; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 12; i++) begin
      if_req = tbl[i].i_req; d_req = tbl[i].dq; d_wea = tbl[i].wea; mem_ready = tbl[i].rdy;
      settle();
      chk($sformatf("tbl%0d_if_gnt", i), if_gnt, tbl[i].e_ig);
      chk($sformatf("tbl%0d_d_gnt", i), d_gnt, tbl[i].e_dg);
      chk($sformatf("tbl%0d_mem_req", i), mem_req, tbl[i].e_mr);
      chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_wea", i), mem_wea, tbl[i].e_wea);
      chk($sformatf("tbl%0d_wdata", i), mem_wdata, tbl[i].e_wdata);
      chk($sformatf("tbl%0d_rvalid", i), {if_rvalid, d_rvalid}, 0);
      next_cycle();
    end
    chk("tbl_state", state_dbg, 0);

    // Single fetch with response two cycles after grant
    do_reset();
    if_req = 1; if_addr = 32'h4000_0000; mem_ready = 1;
    settle();
    chk("fetch_gnt", if_gnt, 1);
    next_cycle();
    if_req = 0;
    settle();
    chk("fetch_wait_rvalid", if_rvalid, 0);
    chk("fetch_wait_mem_req", mem_req, 0);
    next_cycle();
    mem_rvalid = 1; mem_rdata = 32'h0000_0013;
    settle();
    chk("fetch_rvalid", if_rvalid, 1);
    chk("fetch_rdata", if_rdata, 32'h0000_0013);
    chk("fetch_d_rvalid", d_rvalid, 0);
    next_cycle();
    mem_rvalid = 0; mem_rdata = '0;
    settle();
    chk("fetch_back_idle", state_dbg, 0);

    // Contention: both held, memory answers the cycle after each grant
    do_reset();
    for (int i = 0; i < 10; i++) exp_q.push_back((i % 5 == 4) ? 1'b1 : 1'b0);
    begin
      logic pend = 0;
      for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
        if_req = 1; if_addr = 32'h4000_0100; d_req = 1; d_wea = 4'h0; d_addr = 32'h1000;
        mem_ready = 1; mem_rvalid = pend; mem_rdata = 32'h0000_00AA;
        settle();
        if (if_gnt || d_gnt) begin
          logic [0:0] e;
          e = exp_q.pop_front();
          chk("grant_order_i", if_gnt, e);
          chk("grant_order_d", d_gnt, !e);
        end
        pend = if_gnt | d_gnt;
        next_cycle();
      end
      chk("contention_grants_left", exp_q.size(), 0);
      exp_q.delete();
    end

    // Backpressure on a load
    do_reset();
    d_req = 1; d_wea = 4'h0; d_addr = 32'h3000; mem_ready = 0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("bp_no_gnt", d_gnt, 0);
      chk("bp_mem_req", mem_req, 1);
      chk("bp_addr", mem_addr, 32'h3000);
      next_cycle();
    end
    mem_ready = 1;
    settle();
    chk("bp_gnt", d_gnt, 1);
    next_cycle();
    d_req = 0; mem_rvalid = 1; mem_rdata = 32'h0000_CAFE;
    settle();
    chk("bp_rvalid", d_rvalid, 1);
    chk("bp_rdata", d_rdata, 32'h0000_CAFE);
    next_cycle();
    mem_rvalid = 0;

    // Timeout, then the variant where data arrives on the expiry cycle
    for (int v = 0; v < 2; v++) begin
      do_reset();
      if_req = 1; if_addr = 32'h4000_0200; mem_ready = 1;
      settle();
      chk("tmo_gnt", if_gnt, 1);
      next_cycle();
      if_req = 0;
      for (int k = 1; k <= TMO; k++) begin
        if (k == TMO && v == 1) begin mem_rvalid = 1; mem_rdata = 32'h0000_0055; end
        settle();
        if (k < TMO) begin
          chk("tmo_wait_rvalid", if_rvalid, 0);
          chk("tmo_wait_err", err_timeout, 0);
        end else begin
          chk("tmo_rvalid", if_rvalid, 1);
          chk("tmo_rdata", if_rdata, (v == 1) ? 32'h0000_0055 : 32'h0);
          chk("tmo_err", err_timeout, (v == 1) ? 1'b0 : 1'b1);
        end
        next_cycle();
        mem_rvalid = 0; mem_rdata = '0;
      end
      settle();
      chk("tmo_idle", state_dbg, 0);
      chk("tmo_err_after", err_timeout, 0);
      next_cycle();
    end

    // Reset asserted while waiting for load data
    do_reset();
    d_req = 1; d_wea = 4'h0; d_addr = 32'h5000; mem_ready = 1;
    settle();
    chk("rmid_gnt", d_gnt, 1);
    next_cycle();
    d_req = 0;
    settle();
    chk("rmid_wait_d", state_dbg, 2);
    #1;
    d_req = 1; mem_rvalid = 1; mem_rdata = 32'h1234_5678; reset = 0;
    #1;
    chk("rmid_state", state_dbg, 0);
    chk("rmid_outputs", {d_rvalid, if_rvalid, mem_req, d_gnt, err_timeout}, 0);
    chk("rmid_rdata", d_rdata, 0);
    next_cycle();
    reset = 1; d_req = 0;
    settle();
    chk("rmid_late_rvalid", d_rvalid, 0);
    chk("rmid_late_rdata", d_rdata, 0);
    next_cycle();
    mem_rvalid = 0; if_req = 1; if_addr = 32'h4000_0300;
    settle();
    chk("rmid_new_gnt", if_gnt, 1);
    next_cycle();
    if_req = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0077;
    settle();
    chk("rmid_new_rvalid", if_rvalid, 1);
    chk("rmid_new_rdata", if_rdata, 32'h0000_0077);
    next_cycle();

    // Randomized traffic against the reference model
    do_reset();
    owner = 0; since = 0; streak = 0;
    for (int c = 0; c < 2000; c++) begin
      if (!if_req && $urandom_range(1, 0) == 1) begin
        if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req && $urandom_range(1, 0) == 1) begin
        d_req = 1; d_addr = $urandom; d_wdata = $urandom;
        d_wea = ($urandom_range(1, 0) == 1) ? 4'h0 : 4'($urandom_range(15, 1));
      end
      mem_ready  = ($urandom_range(3, 0) != 0);
      mem_rvalid = (owner != 0) ? ($urandom_range(3, 0) == 0) : ($urandom_range(7, 0) == 0);
      mem_rdata  = $urandom;

      e_ig = 0; e_dg = 0; e_mr = 0; e_irv = 0; e_drv = 0; e_err = 0; complete = 0;
      e_addr = '0; e_wdata = '0; e_wea = '0; e_ird = '0; e_drd = '0;
      if (owner == 0) begin
        e_mr = if_req || d_req;
        if (if_req && (!d_req || streak == MAXS)) begin
          e_addr = if_addr; e_ig = mem_ready;
        end else if (d_req) begin
          e_addr = d_addr; e_wea = d_wea; e_wdata = d_wdata; e_dg = mem_ready;
        end
      end else begin
        complete = mem_rvalid || (since == TMO);
        e_err = !mem_rvalid && (since == TMO);
        if (owner == 1) begin
          e_irv = complete; e_ird = mem_rvalid ? mem_rdata : 32'h0;
        end else begin
          e_drv = complete; e_drd = mem_rvalid ? mem_rdata : 32'h0;
        end
      end

      settle();
      chk("rnd_if_gnt", if_gnt, e_ig);
      chk("rnd_d_gnt", d_gnt, e_dg);
      chk("rnd_mem_req", mem_req, e_mr);
      chk("rnd_mem_addr", mem_addr, e_addr);
      chk("rnd_mem_wea", mem_wea, e_wea);
      chk("rnd_mem_wdata", mem_wdata, e_wdata);
      chk("rnd_if_rvalid", if_rvalid, e_irv);
      chk("rnd_if_rdata", if_rdata, e_ird);
      chk("rnd_d_rvalid", d_rvalid, e_drv);
      chk("rnd_d_rdata", d_rdata, e_drd);
      chk("rnd_err_timeout", err_timeout, e_err);

      drop_i = e_ig; drop_d = e_dg;
      if (owner == 0) begin
        if (e_ig) begin
          owner = 1; since = 1; streak = 0;
        end else if (e_dg) begin
          streak = if_req ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
          if (d_wea == 4'h0) begin owner = 2; since = 1; end
        end
      end else if (complete) begin
        owner = 0; since = 0;
      end else begin
        since++;
      end

      next_cycle();
      if (drop_i) if_req = 0;
      if (drop_d) d_req = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
